// File: rtl/rv32_ctrl_pkg.sv
// Shared opcode constants, state encodings and strobe bundle for the RV32I multi-cycle controller.
// No timing of its own; consumed by instr_sequencer and its branch decode.
package rv32_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef struct packed {
    logic imem_en;
    logic ir_load;
    logic pc_write;
    logic pc_sel;
    logic br_un;
    logic reg_wen;
    logic mem_req;
    logic mem_rw;
  } ctrl_t;

  // Stores and branches are the only retiring classes with no destination register.
  function automatic logic writes_rd(input logic [6:0] op);
    return (op != OP_STORE) && (op != OP_BRANCH);
  endfunction

endpackage

// File: rtl/branch_resolver.sv
// Branch condition decode from funct3 and comparator flags; purely combinational.
// Zero latency, no flow control.
module branch_resolver (
  input  logic [2:0] funct3,
  input  logic       br_eq,
  input  logic       br_lt,
  output logic       taken,
  output logic       illegal,
  output logic       br_un
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      3'b000:         taken   = br_eq;
      3'b001:         taken   = !br_eq;
      3'b100, 3'b110: taken   = br_lt;
      3'b101, 3'b111: taken   = !br_lt;
      default:        illegal = 1'b1;
    endcase
  end

  // BLTU/BGEU are the funct3 codes with bit 1 set.
  assign br_un = funct3[1];

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/[MEM]/WB with Moore strobes, retire counter, trap.
// 4 cycles per ALU/branch/jump, 5+N for load/store; DMEM stalls via mem_ready, trapping after MEM_TMO cycles.
module instr_sequencer
  import rv32_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int MEM_TMO = 15
) (
  input  logic             sysCLK,
  input  logic             pRST,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             BrEq,
  input  logic             BrLt,
  input  logic             mem_ready,
  output logic             imem_en,
  output logic             ir_load,
  output logic             pc_write,
  output logic             PCSel,
  output logic             BrUn,
  output logic             RegWEn,
  output logic             mem_req,
  output logic             MemRW,
  output logic [2:0]       state_out,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TMO - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  ctrl_t      ctrl;
  logic       br_taken;
  logic       br_illegal;
  logic       br_un;
  logic       is_branch;

  assign is_branch = (opcode == OP_BRANCH);

  branch_resolver u_branch (
    .funct3  (funct3),
    .br_eq   (BrEq),
    .br_lt   (BrLt),
    .taken   (br_taken),
    .illegal (br_illegal),
    .br_un   (br_un)
  );

  always_ff @(posedge sysCLK) begin
    if (pRST) begin
      state    <= S_IDLE;
      halted   <= 1'b0;
      retired  <= '0;
      wait_cnt <= '0;
    end else begin
      state  <= state_nxt;
      halted <= (state_nxt == S_TRAP);
      if (state == S_WB) retired <= retired + CNT_W'(1);
      // Counter is cleared outside MEM so every MEM entry starts a fresh wait window.
      if (state != S_MEM)  wait_cnt <= '0;
      else if (!mem_ready) wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    ctrl      = '0;
    case (state)
      S_IDLE: if (run) state_nxt = S_FETCH;
      S_FETCH: begin
        ctrl.imem_en = 1'b1;
        state_nxt    = S_DECODE;
      end
      S_DECODE: begin
        ctrl.ir_load = 1'b1;
        state_nxt    = S_EXEC;
      end
      S_EXEC: begin
        ctrl.br_un = is_branch && br_un;
        case (opcode)
          OP_LOAD, OP_STORE:                             state_nxt = S_MEM;
          OP_R, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: state_nxt = S_WB;
          OP_BRANCH: state_nxt = br_illegal ? S_TRAP : S_WB;
          default:                                       state_nxt = S_TRAP;
        endcase
      end
      S_MEM: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_rw  = (opcode == OP_STORE);
        if (mem_ready)                  state_nxt = S_WB;
        else if (wait_cnt == TMO_LAST)  state_nxt = S_TRAP;
      end
      S_WB: begin
        ctrl.pc_write = 1'b1;
        ctrl.reg_wen  = writes_rd(opcode);
        ctrl.pc_sel   = (opcode == OP_JAL) || (opcode == OP_JALR) || (is_branch && br_taken);
        ctrl.br_un    = is_branch && br_un;
        state_nxt     = run ? S_FETCH : S_IDLE;
      end
      S_TRAP: state_nxt = S_TRAP;
      default: state_nxt = S_IDLE;
    endcase
    // Strobes are suppressed during the reset cycle, even mid-transaction.
    if (pRST) ctrl = '0;
  end

  assign imem_en   = ctrl.imem_en;
  assign ir_load   = ctrl.ir_load;
  assign pc_write  = ctrl.pc_write;
  assign PCSel     = ctrl.pc_sel;
  assign BrUn      = ctrl.br_un;
  assign RegWEn    = ctrl.reg_wen;
  assign mem_req   = ctrl.mem_req;
  assign MemRW     = ctrl.mem_rw;
  assign state_out = 3'(state);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: per-instruction expected traces built from instruction semantics,
// compared every cycle on the falling edge, plus literal spot checks.
module tb_instr_sequencer;
  import rv32_ctrl_pkg::*;

  localparam int TMO = 15;

  logic        sysCLK = 1'b0;
  logic        pRST, run, BrEq, BrLt, mem_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        imem_en, ir_load, pc_write, PCSel, BrUn, RegWEn, mem_req, MemRW, halted;
  logic [2:0]  state_out;
  logic [15:0] retired;

  int          checks = 0;
  int          errors = 0;
  int          mem_cnt = 0;
  int          pcs_cnt = 0;
  logic [15:0] m_ret = '0;
  logic        in_idle = 1'b1;
  logic        exp_on = 1'b0;
  logic [27:0] exp_vec = '0;

  instr_sequencer #(.CNT_W(16), .MEM_TMO(TMO)) dut (
    .sysCLK(sysCLK), .pRST(pRST), .run(run), .opcode(opcode), .funct3(funct3),
    .BrEq(BrEq), .BrLt(BrLt), .mem_ready(mem_ready), .imem_en(imem_en),
    .ir_load(ir_load), .pc_write(pc_write), .PCSel(PCSel), .BrUn(BrUn),
    .RegWEn(RegWEn), .mem_req(mem_req), .MemRW(MemRW), .state_out(state_out),
    .halted(halted), .retired(retired)
  );

  always #5 sysCLK = ~sysCLK;

  wire [7:0]  strobes = {imem_en, ir_load, pc_write, PCSel, BrUn, RegWEn, mem_req, MemRW};
  wire [27:0] dut_vec = {state_out, strobes, halted, retired};

  // Expected output vector: state, strobes {imem,ir,pcw,pcsel,brun,regw,mreq,mrw}, halted, retired.
  function automatic logic [27:0] ev(input logic [2:0] st, input logic [7:0] s);
    return {st, s, (st == 3'd6), m_ret};
  endfunction

  always @(negedge sysCLK) begin
    if (mem_req) mem_cnt++;
    if (PCSel && pc_write) pcs_cnt++;
    if (exp_on) begin
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t: got st=%0d strb=%b halt=%b ret=%0d, want st=%0d strb=%b halt=%b ret=%0d",
                 $time, dut_vec[27:25], dut_vec[24:17], dut_vec[16], dut_vec[15:0],
                 exp_vec[27:25], exp_vec[24:17], exp_vec[16], exp_vec[15:0]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic step(input logic [2:0] st, input logic [7:0] s);
    exp_vec = ev(st, s);
    exp_on  = 1'b1;
    @(posedge sysCLK); #1;
  endtask

  task automatic do_reset();
    exp_on = 1'b0; pRST = 1'b1; run = 1'b0; mem_ready = 1'b0;
    @(negedge sysCLK);
    chk("rst_strobes", 32'(strobes), 32'd0);
    @(posedge sysCLK); #1;
    pRST = 1'b0; m_ret = '0; in_idle = 1'b1;
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
  endtask

  task automatic trap_hold();
    for (int i = 0; i < 4; i++) begin
      run = 1'($urandom); mem_ready = 1'($urandom);
      step(3'd6, 8'h00);
    end
    chk("halted_in_trap", 32'(halted), 32'd1);
    do_reset();
  endtask

  task automatic enter_fetch();
    if (in_idle) begin
      run = 1'b0;
      repeat ($urandom_range(0, 2)) step(3'd0, 8'h00);
      run = 1'b1;
      step(3'd0, 8'h00);
      in_idle = 1'b0;
    end
  endtask

  // rdy_at: MEM cycle (1-based) in which mem_ready rises; >TMO never; negative -> pRST in MEM cycle 1-rdy_at.
  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input int rdy_at, input logic run_next);
    logic is_br, is_st, is_mem, legal, taken, lt, brun, regw, pcs;
    enter_fetch();
    is_br  = (op == OP_BRANCH);
    is_st  = (op == OP_STORE);
    is_mem = is_st || (op == OP_LOAD);
    legal  = (op inside {OP_R, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR}) ||
             (is_br && f3 != 3'd2 && f3 != 3'd3);
    lt     = f3[1] ? (a < b) : ($signed(a) < $signed(b));
    case (f3)
      3'd0:    taken = (a == b);
      3'd1:    taken = (a != b);
      3'd4:    taken = $signed(a) <  $signed(b);
      3'd5:    taken = $signed(a) >= $signed(b);
      3'd6:    taken = a < b;
      3'd7:    taken = a >= b;
      default: taken = 1'b0;
    endcase
    brun = is_br && f3[1];
    regw = !(is_st || is_br);
    pcs  = (op == OP_JAL) || (op == OP_JALR) || (is_br && taken);
    opcode = op; funct3 = f3; BrEq = (a == b); BrLt = lt; mem_ready = 1'b0;
    run = 1'($urandom); step(3'd1, 8'h80);
    run = 1'($urandom); step(3'd2, 8'h40);
    run = 1'($urandom); step(3'd3, {4'b0, brun, 3'b0});
    if (is_mem) begin
      for (int k = 1; k <= TMO; k++) begin
        if (rdy_at < 0 && k == 1 - rdy_at) begin
          do_reset();
          return;
        end
        mem_ready = (k == rdy_at); run = 1'($urandom);
        step(3'd4, {6'b0, 1'b1, is_st});
        if (k == rdy_at) break;
      end
      if (rdy_at > TMO) begin
        trap_hold();
        return;
      end
    end else if (!legal) begin
      trap_hold();
      return;
    end
    mem_ready = 1'b0; run = run_next;
    step(3'd5, {2'b0, 1'b1, pcs, brun, regw, 2'b0});
    m_ret++;
    in_idle = !run_next;
  endtask

  logic [6:0]  ops [11];
  logic [31:0] ra, rb;
  int          mc0, pc0;

  initial begin
    ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
            OP_LUI, OP_AUIPC, OP_SYSTEM, 7'b1111111};
    pRST = 1'b1; run = 1'b0; opcode = '0; funct3 = '0;
    BrEq = 1'b0; BrLt = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge sysCLK);
    #1;
    do_reset();

    do_instr(OP_R, 3'd0, 32'd1, 32'd2, 0, 1'b0);
    chk("retired_after_add", 32'(retired), 32'd1);
    chk("idle_after_run_drop", 32'(state_out), 32'd0);

    mc0 = mem_cnt;
    do_instr(OP_LOAD, 3'd2, 32'd0, 32'd0, 3, 1'b1);
    chk("lw_mem_cycles", 32'(mem_cnt - mc0), 32'd3);

    pc0 = pcs_cnt;
    do_instr(OP_BRANCH, 3'd0, 32'd7, 32'd7, 0, 1'b1);
    do_instr(OP_BRANCH, 3'd7, 32'd1, 32'd2, 0, 1'b0);
    chk("pcsel_beq_bgeu", 32'(pcs_cnt - pc0), 32'd1);
    chk("retired_after_4", 32'(retired), 32'd4);

    do_instr(OP_BRANCH, 3'd2, 32'd1, 32'd2, 0, 1'b1);
    chk("retired_cleared_after_trap", 32'(retired), 32'd0);

    mc0 = mem_cnt;
    do_instr(OP_STORE, 3'd2, 32'd0, 32'd0, 99, 1'b1);
    chk("sw_timeout_mem_cycles", 32'(mem_cnt - mc0), 32'd15);

    do_instr(OP_R, 3'd0, 32'd3, 32'd4, 0, 1'b0);
    chk("add_then_idle", 32'(state_out), 32'd0);
    do_instr(OP_SYSTEM, 3'd0, 32'd0, 32'd0, 0, 1'b1);

    do_instr(OP_IMM, 3'd0, 32'd0, 32'd0, 0, 1'b1);
    do_instr(OP_LOAD, 3'd2, 32'd0, 32'd0, -1, 1'b1);

    for (int n = 0; n < 200; n++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      do_instr((n % 17 == 16) ? 7'($urandom) : ops[$urandom_range(0, 10)], 3'($urandom),
               ra, rb, ($urandom_range(0, 9) == 0) ? 99 : $urandom_range(1, 4),
               1'($urandom_range(0, 3) != 0));
    end

    exp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
